decode_issue: RTL and testbench
===============================

# decode_issue

Parametrised decode-and-issue stage that replaces the flat decode stage between fetch and execute. It runs the existing `decoder` on each incoming instruction and reads operands from an internal register file with `NWB` write-back ports. A per-register scoreboard stalls RAW and WAW hazards. Results are registered into an output stage with valid/ready handshakes on both sides, so the stage has one cycle of latency and can back-pressure fetch.

## Interface
Parameters:
- `XLEN`, 64, data/PC width
- `NREG`, 32, architectural registers; register 0 reads zero and is never busy
- `NWB`, 2, write-back ports
- `AW`, `$clog2(NREG)`, derived register-address width; not overridable

Ports:
- `clk`  in  1  clock; everything is on the rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  fetch holds a valid instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_instr`  in  32  raw instruction
- `in_pc`  in  XLEN  instruction PC
- `flush`  in  1  squash the output stage and everything younger
- `out_valid`  out  1  output stage holds an issued instruction
- `out_ready`  in  1  execute consumes the output stage
- `out_ctl`  out  control_t  decoder control bundle
- `out_dst`  out  AW  destination register
- `out_srca`, `out_srcb`  out  XLEN  operand values
- `out_imm`  out  XLEN  immediate
- `out_pc`  out  XLEN  PC of the issued instruction
- `wb_valid`  in  NWB  per-port write strobe
- `wb_addr`  in  NWB×AW  write address
- `wb_data`  in  NWB×XLEN  write data

## Operation
- The existing `decoder` is instantiated unchanged on `in_instr` and produces ctl, ra1, ra2, rdst and imm. "Writes rd" means the decoder's register-write flag is set and rdst≠0.
- Register file: `NREG`×`XLEN` flops; register 0 is constant zero.
- Write-back:
  - For each `wb_valid[i]` with addr≠0, the register is written and `busy[addr]` is cleared.
  - If several ports target the same address in one cycle, the highest index wins.
- Hazard: `busy[ra1] | busy[ra2] | (writes rd & busy[rdst])`, evaluated on the effective busy vector (see Configuration). Both sources are always checked, which is conservative.
- Handshakes:
  - `in_ready = !hazard & (!out_valid | out_ready) & !flush`.
  - Issue occurs when `in_valid & in_ready`.
- On issue:
  - The output stage loads ctl, rdst, operands, imm and PC.
  - `out_valid` is set to 1.
  - If the instruction writes rd, `busy[rdst]` is set. A set and a clear of the same register in the same cycle resolves as set.
- Output stage:
  - If `out_valid & out_ready` and there is no issue, `out_valid` goes to 0.
  - While `out_valid & !out_ready`, all `out_*` hold stable.
- Flush:
  - Next cycle, `out_valid` is 0 and all busy bits are 0.
  - No issue happens in the flush cycle.
  - Write-back ports remain honoured for data in the flush cycle and afterwards; their busy-clear is a no-op.
- Reset:
  - `out_valid` and all `out_*` are 0.
  - All registers and busy bits are 0.
  - `in_ready` is 1 in the first cycle after reset if `out_valid` is 0.
  - Reset mid-stall discards the pending instruction and the output stage.

## Timing
- Latency from issue to `out_valid` is 1 cycle. Peak throughput is 1 instruction per cycle when `out_ready` is held high.
- `in_ready` is combinational from `in_instr`, the busy vector, `out_valid`, `out_ready`, `flush` and, with bypass, `wb_*`. There is no combinational path from `in_valid`.
- Register-file writes become visible to array reads on the cycle after `wb_valid`, unless bypass is compiled in.
- The stage stalls for as long as a hazard register stays busy. It issues on the cycle the clear becomes effective.

## Configuration
- Macro: `DECODE_WB_BYPASS_EN`.
- Defined:
  - Effective busy is `busy & ~(registers cleared by wb this cycle)`.
  - Each operand whose address matches an active wb port takes that port's data, highest index first, instead of the array value.
  - An instruction waiting on a write-back issues in the same cycle as that write-back.
- Undefined:
  - Effective busy is the registered busy vector only, and operands come only from the array.
  - A dependent instruction issues one cycle after the write-back.

## Test plan
- Reset, then write x5=0x1234 via wb0, then issue `add x6,x5,x0` with `out_ready`=1 → `out_valid`=1 one cycle after issue, `out_srca`=0x1234, `out_srcb`=0, `out_dst`=6, `busy[6]`=1.
- Issue `addi x7,x0,1`, then immediately `add x8,x7,x7` → second instruction has `in_ready`=0. With wb0 x7=1:
  - With bypass: it issues in the wb cycle with srca=srcb=1.
  - Without bypass: it issues one cycle later with the same values.
- Hold `out_ready`=0 for 3 cycles with `out_valid`=1 → `out_*` stable, `in_ready`=0; `out_ready`=1 → next instruction issues that cycle, back-to-back.
- wb0 and wb1 both write x9 (0xAA, 0xBB) in one cycle; later read x9 → 0xBB. A wb to x0 with 0xFF → x0 still reads 0.
- `flush` asserted with `busy[6]`=1 and `out_valid`=1 → next cycle `out_valid`=0 and busy all zero. An instruction reading x6 then issues without a stall.
- Assert `reset` while a stalled instruction is waiting on x7 → all outputs zero next cycle, busy cleared, the following x7 reader issues with srca=0.

Source files
------------

// File: rtl/decode_issue.sv
// Decode-and-issue stage: decoder, NWB-port register file, RAW/WAW scoreboard, registered output.
// Optional same-cycle write-back bypass of operands and busy clears: DECODE_WB_BYPASS_EN.

package decode_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_PASS
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    use_imm;
    logic    mem_read;
    logic    mem_write;
    logic    illegal;
    alu_op_e alu_op;
  } control_t;
endpackage

// RV-style integer decoder: control bundle, register indices, sign-extended immediate.
// Latency: combinational. Backpressure: none.
// Register indices are raw instruction fields; callers decide which ones are meaningful.
module decoder #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic [31:0]           i_instr,
  output decode_pkg::control_t  o_ctl,
  output logic [AW-1:0]         o_ra1,
  output logic [AW-1:0]         o_ra2,
  output logic [AW-1:0]         o_rdst,
  output logic [XLEN-1:0]       o_imm
);
  import decode_pkg::*;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;

  assign w_opcode = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign o_ra1    = AW'(i_instr[19:15]);
  assign o_ra2    = AW'(i_instr[24:20]);
  assign o_rdst   = AW'(i_instr[11:7]);

  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_of = sub ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      3'b111:  alu_of = ALU_AND;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

  always_comb begin
    o_ctl  = '0;
    o_imm  = '0;
    case (w_opcode)
      7'h33: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.alu_op    = alu_of(w_f3, i_instr[30]);
      end
      7'h13: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.use_imm   = 1'b1;
        o_ctl.alu_op    = alu_of(w_f3, 1'b0);
        o_imm           = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      end
      7'h03: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.mem_read  = 1'b1;
        o_ctl.use_imm   = 1'b1;
        o_imm           = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      end
      7'h23: begin
        o_ctl.mem_write = 1'b1;
        o_ctl.use_imm   = 1'b1;
        o_imm           = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      7'h37: begin
        o_ctl.reg_write = 1'b1;
        o_ctl.use_imm   = 1'b1;
        o_ctl.alu_op    = ALU_PASS;
        o_imm           = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
      end
      default: o_ctl.illegal = 1'b1;
    endcase
  end
endmodule

// Decode, read operands, stall on busy sources/destination, register into the output stage.
// Latency: 1 cycle from issue to out_valid.
// Backpressure: in_ready drops on hazard, flush, or a held output stage (out_valid & !out_ready).
module decode_issue #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NWB  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [XLEN-1:0]              in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output decode_pkg::control_t         out_ctl,
  output logic [AW-1:0]                out_dst,
  output logic [XLEN-1:0]              out_srca,
  output logic [XLEN-1:0]              out_srcb,
  output logic [XLEN-1:0]              out_imm,
  output logic [XLEN-1:0]              out_pc,
  input  logic [NWB-1:0]               wb_valid,
  input  logic [NWB-1:0][AW-1:0]       wb_addr,
  input  logic [NWB-1:0][XLEN-1:0]     wb_data
);
  import decode_pkg::*;

  control_t          w_ctl;
  logic [AW-1:0]     w_ra1, w_ra2, w_rdst;
  logic [XLEN-1:0]   w_imm, w_srca, w_srcb;
  logic              w_wr_rd, w_hazard, w_in_rdy, w_issue;
  logic [NREG-1:0]   w_wb_clr, w_busy_set, w_busy_eff;

  logic [XLEN-1:0]   r_rf [NREG];
  logic [NREG-1:0]   r_busy;
  logic              r_out_valid;
  control_t          r_out_ctl;
  logic [AW-1:0]     r_out_dst;
  logic [XLEN-1:0]   r_out_srca, r_out_srcb, r_out_imm, r_out_pc;

  decoder #(.XLEN(XLEN), .AW(AW)) u_dec (
    .i_instr (in_instr),
    .o_ctl   (w_ctl),
    .o_ra1   (w_ra1),
    .o_ra2   (w_ra2),
    .o_rdst  (w_rdst),
    .o_imm   (w_imm)
  );

  assign w_wr_rd = w_ctl.reg_write && (w_rdst != '0);

  always_comb begin
    w_wb_clr = '0;
    for (int i = 0; i < NWB; i++)
      if (wb_valid[i] && (wb_addr[i] != '0)) w_wb_clr[wb_addr[i]] = 1'b1;
  end

`ifdef DECODE_WB_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_wb_clr;
`else
  assign w_busy_eff = r_busy;
`endif

  // Both sources are checked regardless of format; cheaper than per-opcode source decode.
  assign w_hazard = w_busy_eff[w_ra1] | w_busy_eff[w_ra2] | (w_wr_rd & w_busy_eff[w_rdst]);
  assign w_in_rdy = !w_hazard && (!r_out_valid || out_ready) && !flush;
  assign w_issue  = in_valid && w_in_rdy;
  assign in_ready = w_in_rdy;

  always_comb begin
    w_srca = (w_ra1 == '0) ? '0 : r_rf[w_ra1];
    w_srcb = (w_ra2 == '0) ? '0 : r_rf[w_ra2];
`ifdef DECODE_WB_BYPASS_EN
    for (int i = 0; i < NWB; i++) begin
      if (wb_valid[i] && (wb_addr[i] != '0) && (wb_addr[i] == w_ra1)) w_srca = wb_data[i];
      if (wb_valid[i] && (wb_addr[i] != '0) && (wb_addr[i] == w_ra2)) w_srcb = wb_data[i];
    end
`endif
  end

  always_comb begin
    w_busy_set = '0;
    if (w_issue && w_wr_rd) w_busy_set[w_rdst] = 1'b1;
  end

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_rf[r] <= '0;
    end else begin
      for (int i = 0; i < NWB; i++)
        if (wb_valid[i] && (wb_addr[i] != '0)) r_rf[wb_addr[i]] <= wb_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) r_busy <= '0;
    else                r_busy <= (r_busy & ~w_wb_clr) | w_busy_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ctl   <= '0;
      r_out_dst   <= '0;
      r_out_srca  <= '0;
      r_out_srcb  <= '0;
      r_out_imm   <= '0;
      r_out_pc    <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_out_ctl   <= w_ctl;
      r_out_dst   <= w_rdst;
      r_out_srca  <= w_srca;
      r_out_srcb  <= w_srcb;
      r_out_imm   <= w_imm;
      r_out_pc    <= in_pc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ctl   = r_out_ctl;
  assign out_dst   = r_out_dst;
  assign out_srca  = r_out_srca;
  assign out_srcb  = r_out_srcb;
  assign out_imm   = r_out_imm;
  assign out_pc    = r_out_pc;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue; issued instructions are scoreboarded and matched at the output.
module tb_decode_issue;
  logic                   clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]            in_instr;
  logic [63:0]            in_pc, out_srca, out_srcb, out_imm, out_pc;
  logic [4:0]             out_dst;
  decode_pkg::control_t   out_ctl;
  logic [1:0]             wb_valid;
  logic [1:0][4:0]        wb_addr;
  logic [1:0][63:0]       wb_data;

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] a, b, imm, pc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctl(out_ctl), .out_dst(out_dst), .out_srca(out_srca),
    .out_srcb(out_srcb), .out_imm(out_imm), .out_pc(out_pc), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    enc_r = {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    enc_i = {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic exp_t mk(input logic [4:0] d, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, input logic [63:0] pc);
    mk = '{dst: d, a: a, b: b, imm: imm, pc: pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each negedge with out_valid & out_ready is exactly one consumption at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_spurious_out", {63'b0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_dst",  {59'b0, out_dst}, {59'b0, e.dst});
        chk("sb_srca", out_srca, e.a);
        chk("sb_srcb", out_srcb, e.b);
        chk("sb_imm",  out_imm,  e.imm);
        chk("sb_pc",   out_pc,   e.pc);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = '0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_out_dst",   {59'b0, out_dst},   64'd0);
    chk("rst_out_srca",  out_srca, 64'd0);
    chk("rst_out_pc",    out_pc,   64'd0);
    chk("rst_busy",      {32'b0, dut.r_busy}, 64'd0);

    // Write x5 then read it back through an issued add.
    tick();
    wb_valid = 2'b01; wb_addr[0] = 5'd5; wb_data[0] = 64'h1234;
    tick();
    wb_valid = '0;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = enc_r(5'd6, 5'd5, 5'd0); in_pc = 64'h100;
    @(negedge clk);
    chk("add6_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd6, 64'h1234, 64'd0, 64'd0, 64'h100));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("add6_out_valid", {63'b0, out_valid}, 64'd1);
    chk("add6_busy6", {63'b0, dut.r_busy[6]}, 64'd1);

    // RAW stall on x7, released by write-back.
    tick();
    in_valid = 1'b1; in_instr = enc_i(5'd7, 5'd0, 12'd1); in_pc = 64'h104;
    @(negedge clk);
    chk("addi7_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd7, 64'd0, 64'd0, 64'd1, 64'h104));
    tick();
    in_instr = enc_r(5'd8, 5'd7, 5'd7); in_pc = 64'h108;
    @(negedge clk);
    chk("raw_stall", {63'b0, in_ready}, 64'd0);
    tick();
    wb_valid = 2'b01; wb_addr[0] = 5'd7; wb_data[0] = 64'd1;
    @(negedge clk);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_wb_cycle_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd8, 64'd1, 64'd1, 64'd0, 64'h108));
    tick();
    wb_valid = '0; in_valid = 1'b0;
`else
    chk("nobyp_wb_cycle_stall", {63'b0, in_ready}, 64'd0);
    tick();
    wb_valid = '0;
    @(negedge clk);
    chk("nobyp_after_wb_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd8, 64'd1, 64'd1, 64'd0, 64'h108));
    tick();
    in_valid = 1'b0;
`endif
    @(negedge clk);
    chk("add8_out_valid", {63'b0, out_valid}, 64'd1);

    // Output backpressure for three cycles, then back-to-back release.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = enc_i(5'd10, 5'd0, 12'd3); in_pc = 64'h10c;
    @(negedge clk);
    chk("addi10_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd10, 64'd0, 64'd0, 64'd3, 64'h10c));
    tick();
    in_instr = enc_i(5'd11, 5'd0, 12'd4); in_pc = 64'h110;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
      chk("hold_out_dst",   {59'b0, out_dst},   64'd10);
      chk("hold_out_imm",   out_imm, 64'd3);
      chk("hold_out_pc",    out_pc,  64'h10c);
      chk("hold_in_ready",  {63'b0, in_ready},  64'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd11, 64'd0, 64'd0, 64'd4, 64'h110));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", {63'b0, out_valid}, 64'd1);

    // Same-address write-back collision, and a write to x0.
    tick();
    wb_valid = 2'b11; wb_addr[0] = 5'd9; wb_addr[1] = 5'd9;
    wb_data[0] = 64'hAA; wb_data[1] = 64'hBB;
    tick();
    wb_valid = 2'b01; wb_addr[0] = 5'd0; wb_data[0] = 64'hFF;
    tick();
    wb_valid = '0;
    in_valid = 1'b1; in_instr = enc_r(5'd12, 5'd0, 5'd9); in_pc = 64'h114;
    @(negedge clk);
    chk("x9_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd12, 64'd0, 64'hBB, 64'd0, 64'h114));
    tick();
    in_valid = 1'b0;

    // Flush with busy[6] set and a held output instruction.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = enc_i(5'd14, 5'd0, 12'd2); in_pc = 64'h118;
    @(negedge clk);
    chk("addi14_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("preflush_out_valid", {63'b0, out_valid}, 64'd1);
    chk("preflush_busy6", {63'b0, dut.r_busy[6]}, 64'd1);
    tick();
    flush = 1'b1;
    in_valid = 1'b1; in_instr = enc_r(5'd15, 5'd6, 5'd0); in_pc = 64'h11c;
    @(negedge clk);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd0);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("postflush_out_valid", {63'b0, out_valid}, 64'd0);
    chk("postflush_busy", {32'b0, dut.r_busy}, 64'd0);
    chk("postflush_in_ready", {63'b0, in_ready}, 64'd1);
    q.push_back(mk(5'd15, 64'd0, 64'd0, 64'd0, 64'h11c));
    tick();
    in_valid = 1'b0;

    // Reset while a reader of x7 is stalled.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = enc_i(5'd7, 5'd0, 12'd3); in_pc = 64'h120;
    @(negedge clk);
    chk("addi7b_in_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_instr = enc_r(5'd16, 5'd7, 5'd0); in_pc = 64'h124;
    @(negedge clk);
    chk("prereset_stall", {63'b0, in_ready}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_out_dst",   {59'b0, out_dst},   64'd0);
    chk("midrst_out_srca",  out_srca, 64'd0);
    chk("midrst_out_imm",   out_imm,  64'd0);
    chk("midrst_out_pc",    out_pc,   64'd0);
    chk("midrst_busy",      {32'b0, dut.r_busy}, 64'd0);
    chk("midrst_in_ready",  {63'b0, in_ready},  64'd1);
    q.push_back(mk(5'd16, 64'd0, 64'd0, 64'd0, 64'h124));
    tick();
    in_valid = 1'b0;

    tick(); tick();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
